// File: rtl/enemy_gunner_if.sv
// enemy_gunner_if: bundles the enemy gunner's game-facing signals.
//
// master modport (enemy_gunner side):
//   in : play, destroy[4:0], player_x[9:0], player_proj_x[9:0], player_proj_y[9:0]
//   out: enemy_x[9:0], enemy_y[9:0], projectiles_x[45:0], projectiles_y[44:0],
//        active[4:0], collide
// slave modport (player / game side): same signals, opposite directions.
interface enemy_gunner_if;
    logic        play;
    logic [4:0]  destroy;
    logic [9:0]  player_x;
    logic [9:0]  player_proj_x;
    logic [9:0]  player_proj_y;
    logic [9:0]  enemy_x;
    logic [9:0]  enemy_y;
    logic [45:0] projectiles_x;
    logic [44:0] projectiles_y;
    logic [4:0]  active;
    logic        collide;

    modport master (
        input  play, destroy, player_x, player_proj_x, player_proj_y,
        output enemy_x, enemy_y, projectiles_x, projectiles_y, active, collide
    );

    modport slave (
        output play, destroy, player_x, player_proj_x, player_proj_y,
        input  enemy_x, enemy_y, projectiles_x, projectiles_y, active, collide
    );
endinterface

// File: rtl/enemy_gunner.sv
// enemy_gunner: enemy ship that patrols horizontally, fires up to five falling
// projectiles, dies when struck by the player's projectile and respawns later.
//
// Ports:
//   clk_4 - game tick clock
//   clr   - asynchronous active-high reset
//   bus   - enemy_gunner_if.master
//           play            1 = game running, 0 = hold in IDLE
//           destroy[4:0]    per-slot retire pulse from the player block
//           player_x        player x (aimed fire only)
//           player_proj_x/y player projectile position (y = 470 means inactive)
//           enemy_x/enemy_y enemy position
//           projectiles_x   slots 0-3 low 9 bits at [9i+8:9i], slot 4 at [45:36]
//           projectiles_y   slot i at [9i+8:9i]
//           active[4:0]     slot live flags
//           collide         one-tick hit pulse
//
// Build option: define AIMED_FIRE_EN to make live projectiles drift one pixel
// per tick toward player_x (clamped to [90,550]); otherwise they fall straight.
module enemy_gunner #(
    parameter int unsigned START_X       = 320,
    parameter int unsigned ENEMY_Y       = 60,
    parameter int unsigned FIRE_PERIOD   = 120,
    parameter int unsigned MOVE_DIV      = 2,
    parameter int unsigned PROJ_STEP     = 2,
    parameter int unsigned RESPAWN_TICKS = 200,
    parameter int unsigned HIT_HALF_W    = 15,
    parameter int unsigned HIT_HALF_H    = 10
) (
    input  logic           clk_4,
    input  logic           clr,
    enemy_gunner_if.master bus
);
    localparam int unsigned NumSlots = 5;
    localparam logic [9:0]  StartX   = 10'(START_X);
    localparam logic [9:0]  EnemyY   = 10'(ENEMY_Y);
    localparam logic [8:0]  SpawnY   = 9'(ENEMY_Y + 10);
    localparam logic [8:0]  ProjStep = 9'(PROJ_STEP);
    localparam logic [9:0]  YBottom  = 10'd470;
    localparam logic [9:0]  XMin     = 10'd90;
    localparam logic [9:0]  XMax     = 10'd550;
    localparam logic [9:0]  HalfW    = 10'(HIT_HALF_W);
    localparam logic [9:0]  HalfH    = 10'(HIT_HALF_H);
    localparam logic [15:0] FireLast = 16'(FIRE_PERIOD - 1);
    localparam logic [15:0] MoveLast = 16'(MOVE_DIV - 1);
    localparam logic [15:0] DeadLast = 16'(RESPAWN_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StPatrol, StDead} state_e;

    state_e      state_q, state_d;
    logic [9:0]  enemy_x_q, enemy_x_d;
    logic        dir_left_q, dir_left_d;
    logic [15:0] move_cnt_q, move_cnt_d;
    logic [15:0] fire_cnt_q, fire_cnt_d;
    logic [15:0] dead_cnt_q, dead_cnt_d;
    logic [9:0]  proj_x_q [NumSlots];
    logic [9:0]  proj_x_d [NumSlots];
    logic [8:0]  proj_y_q [NumSlots];
    logic [8:0]  proj_y_d [NumSlots];
    logic [4:0]  active_q, active_d;
    logic        collide_q, collide_d;

    logic [9:0]  dx, dy;
    logic        hit;
    logic        free_found;
    logic [2:0]  free_idx;

    // Distances are formed larger-minus-smaller so nothing ever wraps.
    always_comb begin
        dx = (bus.player_proj_x >= enemy_x_q) ? bus.player_proj_x - enemy_x_q
                                              : enemy_x_q - bus.player_proj_x;
        dy = (bus.player_proj_y >= EnemyY) ? bus.player_proj_y - EnemyY
                                           : EnemyY - bus.player_proj_y;
        hit = (bus.player_proj_y != YBottom) && (dx < HalfW) && (dy < HalfH);
    end

    // Lowest-index free slot. Uses registered flags, so a slot retired this
    // tick only becomes available on the following tick.
    always_comb begin
        free_found = ~&active_q;
        free_idx   = 3'd0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!active_q[i]) free_idx = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        enemy_x_d  = enemy_x_q;
        dir_left_d = dir_left_q;
        move_cnt_d = move_cnt_q;
        fire_cnt_d = fire_cnt_q;
        dead_cnt_d = dead_cnt_q;
        proj_x_d   = proj_x_q;
        proj_y_d   = proj_y_q;
        active_d   = active_q;
        collide_d  = 1'b0;

        // Live projectiles keep falling in PATROL and DEAD; destroy wins over motion.
        for (int i = 0; i < NumSlots; i++) begin
            if (active_q[i]) begin
                if (bus.destroy[i] ||
                    ({1'b0, proj_y_q[i]} + {1'b0, ProjStep} > YBottom)) begin
                    proj_x_d[i] = '0;
                    proj_y_d[i] = '0;
                    active_d[i] = 1'b0;
                end else begin
                    proj_y_d[i] = proj_y_q[i] + ProjStep;
`ifdef AIMED_FIRE_EN
                    if (bus.player_x > proj_x_q[i] && proj_x_q[i] < XMax) begin
                        proj_x_d[i] = proj_x_q[i] + 10'd1;
                    end else if (bus.player_x < proj_x_q[i] && proj_x_q[i] > XMin) begin
                        proj_x_d[i] = proj_x_q[i] - 10'd1;
                    end
`endif
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.play) state_d = StPatrol;
            end
            StPatrol: begin
                if (hit) begin
                    // The dying tick neither moves nor fires.
                    state_d    = StDead;
                    collide_d  = 1'b1;
                    dead_cnt_d = '0;
                end else begin
                    if (move_cnt_q == MoveLast) begin
                        move_cnt_d = '0;
                        // Flip and step together so x stays inside [90,550].
                        if (!dir_left_q) begin
                            if (enemy_x_q >= XMax) begin
                                dir_left_d = 1'b1;
                                enemy_x_d  = enemy_x_q - 10'd1;
                            end else begin
                                enemy_x_d = enemy_x_q + 10'd1;
                            end
                        end else begin
                            if (enemy_x_q <= XMin) begin
                                dir_left_d = 1'b0;
                                enemy_x_d  = enemy_x_q + 10'd1;
                            end else begin
                                enemy_x_d = enemy_x_q - 10'd1;
                            end
                        end
                    end else begin
                        move_cnt_d = move_cnt_q + 16'd1;
                    end

                    // With every slot busy the counter parks at the last count
                    // so the shot goes out on the first tick a slot is free.
                    if (fire_cnt_q == FireLast) begin
                        if (free_found) begin
                            proj_x_d[free_idx] = enemy_x_q;
                            proj_y_d[free_idx] = SpawnY;
                            active_d[free_idx] = 1'b1;
                            fire_cnt_d         = '0;
                        end
                    end else begin
                        fire_cnt_d = fire_cnt_q + 16'd1;
                    end
                end
            end
            StDead: begin
                if (dead_cnt_q == DeadLast) begin
                    state_d    = StPatrol;
                    enemy_x_d  = StartX;
                    dir_left_d = 1'b0;
                    move_cnt_d = '0;
                    fire_cnt_d = '0;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Leaving the game returns everything to its reset picture.
        if (!bus.play) begin
            state_d    = StIdle;
            enemy_x_d  = StartX;
            dir_left_d = 1'b0;
            move_cnt_d = '0;
            fire_cnt_d = '0;
            dead_cnt_d = '0;
            active_d   = '0;
            collide_d  = 1'b0;
            for (int i = 0; i < NumSlots; i++) begin
                proj_x_d[i] = '0;
                proj_y_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_4 or posedge clr) begin
        if (clr) begin
            state_q    <= StIdle;
            enemy_x_q  <= StartX;
            dir_left_q <= 1'b0;
            move_cnt_q <= '0;
            fire_cnt_q <= '0;
            dead_cnt_q <= '0;
            active_q   <= '0;
            collide_q  <= 1'b0;
            for (int i = 0; i < NumSlots; i++) begin
                proj_x_q[i] <= '0;
                proj_y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            enemy_x_q  <= enemy_x_d;
            dir_left_q <= dir_left_d;
            move_cnt_q <= move_cnt_d;
            fire_cnt_q <= fire_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            active_q   <= active_d;
            collide_q  <= collide_d;
            proj_x_q   <= proj_x_d;
            proj_y_q   <= proj_y_d;
        end
    end

    assign bus.enemy_x       = enemy_x_q;
    assign bus.enemy_y       = EnemyY;
    assign bus.active        = active_q;
    assign bus.collide       = collide_q;
    assign bus.projectiles_x = {proj_x_q[4], proj_x_q[3][8:0], proj_x_q[2][8:0],
                                proj_x_q[1][8:0], proj_x_q[0][8:0]};
    assign bus.projectiles_y = {proj_y_q[4], proj_y_q[3], proj_y_q[2],
                                proj_y_q[1], proj_y_q[0]};

    // Slots 0-3 only expose 9 bits of x on the bus.
    logic unused_x_msb;
    assign unused_x_msb = proj_x_q[0][9] ^ proj_x_q[1][9] ^ proj_x_q[2][9] ^ proj_x_q[3][9];

`ifdef AIMED_FIRE_EN
`else
    logic unused_player_x;
    assign unused_player_x = ^bus.player_x;
`endif
endmodule
